// File: rtl/vga_pkg.sv
// vga_pkg: definitions shared by the VGA pattern generator files.
//   - default active-area geometry, colour-bar width and checker size
//   - pattern_t: the six selectable test patterns, in button order
//   - next_pattern(): the button-step order, wrapping after the last pattern
//   - sat_inc10(): 10-bit increment that holds at 1023
package vga_pkg;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int BAR_WIDTH_DEF  = 80;
  localparam int CHECK_LOG2_DEF = 5;
  localparam int PAT_COUNT      = 6;

  typedef enum logic [2:0] {
    PAT_WHITE  = 3'd0,
    PAT_BARS   = 3'd1,
    PAT_CHECK  = 3'd2,
    PAT_RAMP   = 3'd3,
    PAT_BORDER = 3'd4,
    PAT_STRIPE = 3'd5
  } pattern_t;

  function automatic pattern_t next_pattern(input pattern_t p);
    if (int'(p) >= PAT_COUNT - 1) return PAT_WHITE;
    return pattern_t'(p + 3'd1);
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_pixel_tracker.sv
// vga_pixel_tracker: first pipeline stage of the pattern generator.
// Registers the incoming sync/visible flags and recovers the position of
// the pixel it has just registered, so every output below describes the
// same pixel.
// Ports:
//   i_Clk, i_Reset          pixel clock, synchronous active-high reset
//   i_HSync, i_VSync        active-low syncs from the sync processor
//   i_Colour_On             high during visible pixels
//   r_Active                registered i_Colour_On
//   r_HSync, r_VSync        registered syncs (reset to 1, inactive)
//   col, row                pixel column / row, 0-based, saturating at 1023
//   bar                     colour-bar index of col, 0..7 (saturating)
module vga_pixel_tracker
  import vga_pkg::*;
#(
  parameter int BAR_WIDTH = BAR_WIDTH_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic       i_Colour_On,
  output logic       r_Active,
  output logic       r_HSync,
  output logic       r_VSync,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic [2:0] bar
);

  localparam logic [9:0] BAR_LAST = 10'(BAR_WIDTH - 1);

  // Pixel count within the current bar; runs alongside col so no divider
  // is needed to find the bar index.
  logic [9:0] bar_cnt;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Active <= 1'b0;
      r_HSync  <= 1'b1;
      r_VSync  <= 1'b1;
      col      <= '0;
      row      <= '0;
      bar      <= '0;
      bar_cnt  <= '0;
    end else begin
      r_Active <= i_Colour_On;
      r_HSync  <= i_HSync;
      r_VSync  <= i_VSync;

      // First visible pixel of a line restarts the column; blanking holds.
      if (i_Colour_On) begin
        if (!r_Active) begin
          col     <= '0;
          bar     <= '0;
          bar_cnt <= '0;
        end else begin
          col <= sat_inc10(col);
          if (bar_cnt == BAR_LAST) begin
            bar_cnt <= '0;
            if (bar != 3'd7) bar <= bar + 3'd1;
          end else begin
            bar_cnt <= bar_cnt + 10'd1;
          end
        end
      end

      // VSync falling edge restarts the frame and beats a line end that
      // lands on the same clock.
      if (!i_VSync && r_VSync) begin
        row <= '0;
      end else if (!i_Colour_On && r_Active) begin
        row <= sat_inc10(row);
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern generator behind the VGA sync processor.
// Consumes a continuous sync/visible stream, one pixel per clock, with no
// handshake: every clock carries a pixel and every clock produces one.
// Colour and syncs appear 2 clocks after the inputs. A rising edge on
// i_Pattern_Next requests the next pattern; the request is applied only
// at a VSync falling edge, so a frame never shows two patterns.
// Ports:
//   i_Clk, i_Reset          pixel clock, synchronous active-high reset
//   i_HSync, i_VSync        active-low syncs in
//   i_Colour_On             high during visible pixels
//   i_Pattern_Next          debounced button level
//   o_Red, o_Grn, o_Blu     3-bit colour, 0 outside the visible area
//   o_HSync, o_VSync        syncs delayed 2 clocks to line up with colour
//   o_Pattern               active pattern index 0..5
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int BAR_WIDTH  = BAR_WIDTH_DEF,
  parameter int CHECK_LOG2 = CHECK_LOG2_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic       i_Colour_On,
  input  logic       i_Pattern_Next,
  output logic [2:0] o_Red,
  output logic [2:0] o_Grn,
  output logic [2:0] o_Blu,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [2:0] o_Pattern
);

  localparam logic [9:0] COL_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] ROW_LAST = 10'(V_ACTIVE - 1);

  // Stage 1: position of the registered pixel.
  logic       r_Active;
  logic       r_HSync;
  logic       r_VSync;
  logic [9:0] col;
  logic [9:0] row;
  logic [2:0] bar;

  vga_pixel_tracker #(
    .BAR_WIDTH(BAR_WIDTH)
  ) u_tracker (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_HSync    (i_HSync),
    .i_VSync    (i_VSync),
    .i_Colour_On(i_Colour_On),
    .r_Active   (r_Active),
    .r_HSync    (r_HSync),
    .r_VSync    (r_VSync),
    .col        (col),
    .row        (row),
    .bar        (bar)
  );

  // Pattern control.
  logic     r_Btn;
  logic     r_Pending;
  pattern_t pattern;
  logic     press;
  logic     vs_fall;

  assign press   = i_Pattern_Next & ~r_Btn;
  assign vs_fall = ~i_VSync & r_VSync;

  // Presses only latch a request; however many arrive in a frame, the
  // frame boundary advances the pattern by one. A press on the boundary
  // clock itself is honoured straight away.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Btn     <= 1'b0;
      r_Pending <= 1'b0;
      pattern   <= PAT_WHITE;
    end else begin
      r_Btn <= i_Pattern_Next;
      if (vs_fall && (r_Pending || press)) begin
        pattern   <= next_pattern(pattern);
        r_Pending <= 1'b0;
      end else if (press) begin
        r_Pending <= 1'b1;
      end
    end
  end

  assign o_Pattern = pattern;

  // Stage 2: colour of the registered pixel.
  logic [2:0] red_d;
  logic [2:0] grn_d;
  logic [2:0] blu_d;
  logic [2:0] bar_c;

  always_comb begin
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    bar_c = 3'd7 - bar;  // bar 0 white down to bar 7 black
    if (r_Active) begin
      case (pattern)
        PAT_WHITE: begin
          red_d = 3'd7;
          grn_d = 3'd7;
          blu_d = 3'd7;
        end
        PAT_BARS: begin
          red_d = {3{bar_c[2]}};
          grn_d = {3{bar_c[1]}};
          blu_d = {3{bar_c[0]}};
        end
        PAT_CHECK: begin
          red_d = {3{col[CHECK_LOG2] ^ row[CHECK_LOG2]}};
          grn_d = red_d;
          blu_d = red_d;
        end
        PAT_RAMP: begin
          red_d = bar;
        end
        PAT_BORDER: begin
          red_d = {3{(col == '0) || (col == COL_LAST) ||
                     (row == '0) || (row == ROW_LAST)}};
          grn_d = red_d;
          blu_d = red_d;
        end
        PAT_STRIPE: begin
          grn_d = {3{row[3]}};
        end
        default: begin
          red_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Red   <= '0;
      o_Grn   <= '0;
      o_Blu   <= '0;
      o_HSync <= 1'b1;
      o_VSync <= 1'b1;
    end else begin
      o_Red   <= red_d;
      o_Grn   <= grn_d;
      o_Blu   <= blu_d;
      o_HSync <= r_HSync;
      o_VSync <= r_VSync;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: drives a scaled-down VGA raster (64x40 visible,
// 80x46 total) into vga_pattern_gen and compares every output pixel and
// sync against a model computed from raster coordinates.
module tb_vga_pattern_gen;

  localparam int H_ACT  = 64;
  localparam int H_FP   = 4;
  localparam int H_SYNC = 8;
  localparam int H_TOT  = 80;
  localparam int V_ACT  = 40;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_TOT  = 46;
  localparam int BAR_W  = 8;
  localparam int CHK    = 2;
  localparam int VS_ROW = V_ACT + V_FP;  // line on which VSync falls

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic       hsync_in;
  logic       vsync_in;
  logic       colour_on;
  logic       pat_next;
  logic [2:0] red;
  logic [2:0] grn;
  logic [2:0] blu;
  logic       hsync_out;
  logic       vsync_out;
  logic [2:0] pattern;

  always #20 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE  (H_ACT),
    .V_ACTIVE  (V_ACT),
    .BAR_WIDTH (BAR_W),
    .CHECK_LOG2(CHK)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_HSync       (hsync_in),
    .i_VSync       (vsync_in),
    .i_Colour_On   (colour_on),
    .i_Pattern_Next(pat_next),
    .o_Red         (red),
    .o_Grn         (grn),
    .o_Blu         (blu),
    .o_HSync       (hsync_out),
    .o_VSync       (vsync_out),
    .o_Pattern     (pattern)
  );

  // Scoreboard: entry = {check_colour, rgb[8:0], hsync, vsync}
  logic [11:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Model state, kept in raster terms
  int   h = 0;
  int   v = 0;
  int   model_pat = 0;
  int   presses_this_frame = 0;
  int   btn_req = 0;
  logic prev_vs = 1'b1;
  logic prev_btn = 1'b0;
  logic colour_ok = 1'b0;
  logic pat_chk_en = 1'b0;
  int   exp_pat = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at v=%0d h=%0d: got=%0h expected=%0h", tag, v, h, got, exp);
    end
  endtask

  function automatic logic [8:0] model_rgb(input int pat, input int x, input int y);
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    int bar_idx;
    int c;
    r = 3'd0;
    g = 3'd0;
    b = 3'd0;
    bar_idx = x / BAR_W;
    if (bar_idx > 7) bar_idx = 7;
    c = 7 - bar_idx;
    case (pat)
      0: begin r = 3'd7; g = 3'd7; b = 3'd7; end
      1: begin
        r = ((c & 4) != 0) ? 3'd7 : 3'd0;
        g = ((c & 2) != 0) ? 3'd7 : 3'd0;
        b = ((c & 1) != 0) ? 3'd7 : 3'd0;
      end
      2: if ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) begin
        r = 3'd7; g = 3'd7; b = 3'd7;
      end
      3: r = 3'(bar_idx);
      4: if (x == 0 || x == H_ACT - 1 || y == 0 || y == V_ACT - 1) begin
        r = 3'd7; g = 3'd7; b = 3'd7;
      end
      5: g = (((y >> 3) & 1) != 0) ? 3'd7 : 3'd0;
      default: r = 3'd0;
    endcase
    return {r, g, b};
  endfunction

  // Driver: one pixel per call. Checks the outputs due this clock, then
  // drives the next raster position and records what it must produce.
  task automatic cycle(input logic do_rst);
    logic [11:0] e;
    logic        de;
    logic        hs;
    logic        vs;
    logic        btn;
    logic        press;
    logic        vs_fall;
    @(negedge clk);
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check("hsync", 32'(hsync_out), 32'(e[1]));
      check("vsync", 32'(vsync_out), 32'(e[0]));
      if (e[11]) check("rgb", 32'({red, grn, blu}), 32'(e[10:2]));
    end
    if (pat_chk_en) check("pattern", 32'(pattern), 32'(exp_pat));

    de  = (h < H_ACT) && (v < V_ACT);
    hs  = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC));
    vs  = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC));
    btn = (btn_req > 0);
    if (btn_req > 0) btn_req--;

    if (do_rst) begin
      // Everything restarts; colour is untrusted until a frame boundary.
      model_pat = 0;
      presses_this_frame = 0;
      prev_vs = 1'b1;
      prev_btn = 1'b0;
      colour_ok = 1'b0;
      exp_q.delete();
      exp_q.push_back({1'b1, 9'h0, 1'b1, 1'b1});
      exp_q.push_back({1'b1, 9'h0, 1'b1, 1'b1});
      exp_pat = 0;
      pat_chk_en = 1'b1;
      btn = 1'b0;
    end else begin
      press   = btn && !prev_btn;
      vs_fall = !vs && prev_vs;
      if (press) presses_this_frame++;
      if (vs_fall) begin
        if (presses_this_frame > 0) model_pat = (model_pat + 1) % 6;
        presses_this_frame = 0;
        colour_ok = 1'b1;
      end
      exp_q.push_back({colour_ok, de ? model_rgb(model_pat, h, v) : 9'h0, hs, vs});
      exp_pat = model_pat;
      prev_vs = vs;
      prev_btn = btn;
    end

    rst       = do_rst;
    hsync_in  = hs;
    vsync_in  = vs;
    colour_on = de;
    pat_next  = btn;

    h++;
    if (h == H_TOT) begin
      h = 0;
      v++;
      if (v == V_TOT) v = 0;
    end
  endtask

  // Run until the next pixel to drive is (vt, ht); bounded by one frame.
  task automatic run_to(input int vt, input int ht);
    for (int n = 0; n <= H_TOT * V_TOT; n++) begin
      if (v == vt && h == ht) return;
      cycle(1'b0);
    end
    check("run_to_bound", 32'(v * H_TOT + h), 32'(vt * H_TOT + ht));
  endtask

  task automatic press_at(input int vt, input int ht);
    run_to(vt, ht);
    btn_req = 3;
  endtask

  initial begin
    rst = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    colour_on = 1'b0;
    pat_next = 1'b0;

    repeat (2) cycle(1'b1);
    // Stream starts at the top-left pixel, which is where a fresh reset
    // leaves the counters, so the first frame is already checkable.
    h = 0;
    v = 0;
    colour_ok = 1'b1;

    // Frame 0: white; press mid-frame takes effect only at the boundary.
    press_at(20, 30);
    run_to(0, 0);
    // Frame 1: bars; three presses advance by one only.
    press_at(int'($urandom_range(0, 10)), int'($urandom_range(0, H_TOT - 1)));
    press_at(int'($urandom_range(13, 23)), int'($urandom_range(0, H_TOT - 1)));
    press_at(int'($urandom_range(26, 36)), int'($urandom_range(0, H_TOT - 1)));
    run_to(0, 0);
    // Frames 2..5: checker, ramp, border, stripes, then wrap to white.
    for (int f = 0; f < 4; f++) begin
      press_at(int'($urandom_range(0, V_ACT - 2)), int'($urandom_range(0, H_TOT - 1)));
      run_to(0, 0);
    end
    // Frame 6: white; press on the very clock VSync falls.
    press_at(VS_ROW, 0);
    run_to(0, 0);
    // Frame 7: bars; pending press wiped by a mid-frame reset.
    press_at(int'($urandom_range(0, 15)), int'($urandom_range(0, H_TOT - 1)));
    run_to(20, 30);
    cycle(1'b1);
    run_to(0, 0);
    // Frame 8: white after reset; one press gives bars in frame 9.
    press_at(int'($urandom_range(0, V_ACT - 2)), int'($urandom_range(0, H_TOT - 1)));
    run_to(0, 0);
    run_to(V_ACT + 1, 0);
    repeat (3) cycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Downstream of the VGA sync processor: consumes its HSync/VSync/Colour_On stream, recovers pixel column/row, and drives 3-bit Red/Green/Blue test patterns with the syncs re-aligned. A debounced button steps through six patterns. The change takes effect only at frame boundaries, so it never tears mid-frame. The current pattern index is exported for the character segment display.

## Interface
- H_ACTIVE, 640: visible pixels per line (col saturates at 1023)
- V_ACTIVE, 480: visible lines per frame
- BAR_WIDTH, 80: colour-bar width in pixels
- CHECK_LOG2, 5: checkerboard square = 2^CHECK_LOG2 pixels

Ports:
- i_Clk  in  1  pixel clock (25 MHz)
- i_Reset  in  1  reset; one clock, synchronous, active-high
- i_HSync  in  1  active-low horizontal sync from sync processor
- i_VSync  in  1  active-low vertical sync from sync processor
- i_Colour_On  in  1  high during visible pixels
- i_Pattern_Next  in  1  debounced button level; a rising edge requests the next pattern
- o_Red, o_Grn, o_Blu  out  3 each  pixel colour, 0..7
- o_HSync, o_VSync  out  1  syncs delayed to match colour
- o_Pattern  out  3  active pattern index 0..5

## Operation
- Stage 1 registers r_Active, r_HSync and r_VSync from the inputs and updates the counters.
- col (10b):
  - if i_Colour_On, col <= r_Active ? col+1 (saturate 1023) : 0
  - else hold
- bar (3b) and bar_cnt: tracked alongside col.
  - Both reset to 0 when col resets.
  - bar increments when bar_cnt reaches BAR_WIDTH-1, saturating at 7.
- row (10b):
  - increments (saturate 1023) on the falling edge of i_Colour_On (i_Colour_On=0, r_Active=1)
  - resets to 0 on the VSync falling edge (i_VSync=0, r_VSync=1)
  - the VSync reset wins when both occur together
- Pattern control:
  - A rising edge of i_Pattern_Next sets r_Pending.
  - On a VSync falling edge with r_Pending (or with a press edge in the same cycle): pattern <= (pattern==5) ? 0 : pattern+1, then r_Pending clears.
  - Any number of presses within one frame advance the pattern by exactly 1.
- Stage 2 registers the colour and the syncs. Colour is 0 when r_Active=0. Patterns:
  - 0 solid white: 7/7/7
  - 1 colour bars: c = 7-bar; each channel = 7 if its bit of c is set (R=c[2], G=c[1], B=c[0]); bar 0 white, bar 7 black
  - 2 checkerboard: white if col[CHECK_LOG2]^row[CHECK_LOG2], else black
  - 3 red ramp: R = bar, G = B = 0
  - 4 border: white if col==0, col==H_ACTIVE-1, row==0 or row==V_ACTIVE-1, else black
  - 5 stripes: G = 7 if row[3], else 0; R = B = 0
- Reset values:
  - outputs: RGB 0, o_HSync=1, o_VSync=1, o_Pattern=0
  - internal: col/row/bar/bar_cnt 0, r_Active 0, r_HSync/r_VSync 1, r_Pending 0, button history 0
- Reset mid-frame: counters restart at 0. The first complete line after the next VSync edge is correct.

## Timing
- Latency is 2 clocks from inputs to o_Red/o_Grn/o_Blu/o_HSync/o_VSync. Syncs are delayed by exactly 2 so they stay aligned with colour.
- o_Pattern updates 1 clock after the VSync falling edge is sampled. Colour uses the new pattern from that cycle onward, before the first visible line.
- There is no handshake. Input is a continuous stream, one pixel per clock.

## Structure
- Shared package vga_pkg holds:
  - the H_ACTIVE/V_ACTIVE defaults
  - the pattern enum (PAT_WHITE, PAT_BARS, PAT_CHECK, PAT_RAMP, PAT_BORDER, PAT_STRIPE)
  - PAT_COUNT=6
- Sub-module vga_pixel_tracker holds the stage-1 counters (col, row, bar, r_Active, delayed syncs). The top level keeps pattern control and colour generation.

## Test plan
- Reset, then drive an 800x525 stream from a model sync generator, pattern 0 → every visible pixel 7/7/7, blanking 0; o_HSync/o_VSync equal the inputs delayed 2 clocks.
- Pattern 1 → pixels 0..79 white, 80..159 R=7,G=7,B=0 (c=6), 560..639 black; the transition falls exactly at col 80.
- Press at mid-frame row 200 → pattern stays 0 through row 479. o_Pattern=1 one clock after the VSync edge, and the next frame shows bars.
- Three presses in one frame → pattern advances by 1 only. At pattern 5, one press followed by a VSync edge → 0.
- Pattern 4 → col 0 and 639 white on all rows; row 0 and 479 fully white; pixel (1,1) black.
- i_Reset asserted at row 240, col 300 → next clock shows all outputs at reset values. After the next VSync edge, frame output matches the golden model.
